// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the 5-stage CPU: run/halt/step FSM,
// load-use stall and branch/jump flush generation, saturating debug counters.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             cnt_clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_waddr,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]  DRAIN_ZERO = {DW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [DW-1:0]    drain_cnt_r;
  logic [DW-1:0]    drain_cnt_s;
  logic [CNT_W-1:0] stall_cnt_s;
  logic [CNT_W-1:0] flush_cnt_s;
  logic             lu_s;
  logic             fl_s;
  logic             active_s;

  // Hazard detection on the current ID and EX contents
  always_comb begin
    lu_s     = ex_mem_read & (ex_waddr != 5'd0) &
               ((ex_waddr == id_rs) | (id_uses_rt & (ex_waddr == id_rt)));
    fl_s     = ex_branch_taken | ex_jump;
    active_s = (state_r == RUN) | (state_r == STEP) | (state_r == DRAIN);
  end

  // Pipeline enables/flushes: a taken control transfer outranks a load-use stall
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b0;
    case (state_r)
      RUN, STEP, DRAIN: begin
        pipe_en = 1'b1;
        if (fl_s) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu_s) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b1;
        end else if (state_r == DRAIN) begin
          // Fetched instruction is discarded and refetched on resume
          pc_en       = 1'b0;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b0;
        end else begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b0;
        end
      end
      IDLE, HALTED: begin
        pipe_en = 1'b0;
      end
      default: begin
        pipe_en = 1'b0;
      end
    endcase
  end

  // Next state and drain down-counter
  always_comb begin
    state_s     = state_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      IDLE: begin
        if (run_req) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_s     = DRAIN;
          drain_cnt_s = DRAIN_LOAD;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (fl_s) begin
          drain_cnt_s = DRAIN_LOAD;
        end else if (lu_s) begin
          drain_cnt_s = drain_cnt_r;
        end else if (drain_cnt_r == DRAIN_ZERO) begin
          state_s = HALTED;
        end else begin
          drain_cnt_s = drain_cnt_r - DW'(1);
        end
      end
      HALTED: begin
        if (run_req) begin
          state_s = RUN;
        end else if (step_req) begin
          state_s = STEP;
        end else begin
          state_s = HALTED;
        end
      end
      STEP: begin
        state_s = HALTED;
      end
      default: begin
        state_s     = IDLE;
        drain_cnt_s = DRAIN_ZERO;
      end
    endcase
  end

  // Saturating event counters; clear overrides any same-cycle increment
  always_comb begin
    stall_cnt_s = stall_cnt;
    flush_cnt_s = flush_cnt;
    if (cnt_clr) begin
      stall_cnt_s = CNT_ZERO;
      flush_cnt_s = CNT_ZERO;
    end else if (active_s && fl_s) begin
      if (flush_cnt != CNT_MAX) begin
        flush_cnt_s = flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt_s = flush_cnt;
      end
    end else if (active_s && lu_s) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt_s = stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt_s = stall_cnt;
      end
    end else begin
      stall_cnt_s = stall_cnt;
      flush_cnt_s = flush_cnt;
    end
  end

  // State, drain counter, halted flag and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= DRAIN_ZERO;
      halted      <= 1'b0;
      stall_cnt   <= CNT_ZERO;
      flush_cnt   <= CNT_ZERO;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
      halted      <= (state_s == HALTED);
      stall_cnt   <= stall_cnt_s;
      flush_cnt   <= flush_cnt_s;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing and hazard controller for the 5-stage pipelined CPU. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and runs a run/halt/single-step state machine. In RUN it inserts load-use stalls and flushes on taken branches and jumps. It also keeps saturating stall and flush event counters for debug.

## Interface
Parameters:
- DRAIN_CYCLES, 4, cycles of bubble insertion needed to empty ID..WB after a halt request
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  main clock, rising edge
- rst  in  1  synchronous, active-high reset
- run_req  in  1  level; start or resume execution
- halt_req  in  1  level; request halt (drain, then stop)
- step_req  in  1  single-cycle pulse; advance one cycle while halted
- cnt_clr  in  1  synchronous clear of both counters
- id_rs  in  5  rs field of the IF/ID instruction
- id_rt  in  5  rt field of the IF/ID instruction
- id_uses_rt  in  1  IF/ID instruction reads rt as a source (R-type, beq, sw)
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_waddr  in  5  ID/EX destination register
- ex_branch_taken  in  1  branch in EX with zero_flag set
- ex_jump  in  1  jump in EX
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a bubble (all zero)
- id_ex_flush  out  1  ID/EX loads a bubble (control signals zero)
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB
- halted  out  1  core is stopped and drained
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  control-hazard flush cycles

## Operation
States: IDLE, RUN, DRAIN, HALTED, STEP. Reset state is IDLE.

Hazard terms:
- lu = ex_mem_read & (ex_waddr != 0) & ((ex_waddr == id_rs) | (id_uses_rt & (ex_waddr == id_rt)))
- fl = ex_branch_taken | ex_jump

Outputs per state:
- IDLE, HALTED: all enables and flushes are 0.
- RUN, STEP: pipe_en=1. The first matching case applies.
  - fl: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1.
  - lu: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1.
  - Otherwise: pc_en=1, if_id_en=1, flushes 0.
- DRAIN: pipe_en=1. The first matching case applies.
  - fl: same as the RUN case; the PC loads the target so execution resumes there.
  - lu: same as the RUN case; the down-counter holds.
  - Otherwise: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_flush=0. The IF instruction is discarded and refetched on resume.
- halted = (state == HALTED).

Transitions, evaluated at each rising edge, highest priority first:
- IDLE: run_req -> RUN.
- RUN: halt_req -> DRAIN with drain counter = DRAIN_CYCLES-1. halt_req wins over a simultaneous run_req.
- DRAIN:
  - fl reloads the counter to DRAIN_CYCLES-1.
  - lu holds the counter.
  - Otherwise the counter decrements.
  - Counter == 0 and neither fl nor lu -> HALTED.
  - run_req and step_req are ignored in DRAIN.
- HALTED: run_req -> RUN; else step_req -> STEP. halt_req is ignored.
- STEP: unconditionally -> HALTED after one cycle.

Counters:
- stall_cnt increments in each RUN/STEP/DRAIN cycle where lu is set and fl is not.
- flush_cnt increments in each RUN/STEP/DRAIN cycle where fl is set.
- Both saturate at 2^CNT_W-1.
- cnt_clr forces both to 0 and overrides an increment in the same cycle.

## Timing
- Reset: rst sampled high at an edge sets state=IDLE, drain counter=0, stall_cnt=0, flush_cnt=0. All outputs read 0 from the next cycle. rst mid-DRAIN or mid-STEP aborts with no completion.
- Enables and flushes are combinational from the registered state and the current hazard inputs. They are valid in the same cycle and have zero latency.
- halted is Moore. When halt_req is asserted in RUN cycle n and no hazards occur, halted first reads 1 in cycle n+1+DRAIN_CYCLES.
- run_req in IDLE or HALTED at cycle n: pc_en reads 1 in cycle n+1.
- step_req gives exactly one cycle of RUN behaviour, then halted=1 again. A step_req held for several cycles is re-sampled only in HALTED, so it yields one step every 2 cycles.
- Counters are registered; an increment is visible the cycle after the event.

## Test plan
- Reset then run: rst=1 for 2 cycles, then run_req=1 -> all outputs 0 during reset, then pc_en=if_id_en=pipe_en=1 and halted=0 one cycle after run_req.
- Load-use: RUN, ex_mem_read=1, ex_waddr=5, id_rs=5 -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt goes 0->1. Same stimulus with ex_waddr=0 gives no stall.
- Branch vs load-use collision: in RUN assert lu and ex_branch_taken together -> flush outputs (if_id_flush=id_ex_flush=pc_en=1); flush_cnt increments, stall_cnt does not.
- Halt drain with DRAIN_CYCLES=4: halt_req at cycle 10 -> pc_en=0 and if_id_flush=1 for cycles 11-14, halted=1 from cycle 15. Repeat with lu in cycle 12 -> halted delayed to cycle 16.
- Single step: in HALTED pulse step_req -> exactly one cycle with pc_en=1, then halted=1. With run_req and step_req together -> RUN.
- Counter saturation and clear: CNT_W=4, 20 consecutive lu cycles -> stall_cnt=15. cnt_clr with lu in the same cycle -> stall_cnt=0 next cycle.
